// File: rtl/lifegame_frame_sequencer.sv
// Life-game board memory sequencer on the pixel clock.
// Seeds the board, then arbitrates the memory port between scan-out and update.
module lifegame_frame_sequencer #(
    parameter int COLS        = 64,
    parameter int ROWS        = 48,
    parameter int GEN_DIV     = 4,
    parameter int UPD_TIMEOUT = 65535,
    localparam int N          = COLS * ROWS,
    localparam int AW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          seed_bit,
    input  logic          frame_start,
    input  logic          run,
    input  logic          step,
    input  logic          reseed,
    input  logic          upd_done,
    output logic          upd_start,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_data,
    output logic          vga_own,
    output logic          busy,
    output logic [15:0]   gen_count,
    output logic          err
);

    localparam int FW = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
    localparam int TW = $clog2(UPD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        SEED,
        IDLE,
        UPDATE
    } state_t;

    state_t        state, state_nxt;
    logic          wr_en_nxt;
    logic [AW-1:0] wr_addr_nxt;
    logic          upd_start_nxt;
    logic          vga_own_nxt;
    logic          busy_nxt;
    logic [15:0]   gen_count_nxt;
    logic          err_nxt;
    logic [FW-1:0] frame_cnt, frame_cnt_nxt;
    logic          step_pend, step_pend_nxt;
    logic          reseed_pend, reseed_pend_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    // Seed data only reaches memory while the seed strobe is active
    assign wr_data = seed_bit & wr_en;

    // State and registered outputs; reset restarts seeding from address 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SEED;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            upd_start   <= 1'b0;
            vga_own     <= 1'b0;
            busy        <= 1'b1;
            gen_count   <= '0;
            err         <= 1'b0;
            frame_cnt   <= '0;
            step_pend   <= 1'b0;
            reseed_pend <= 1'b0;
            tcnt        <= '0;
        end else begin
            state       <= state_nxt;
            wr_en       <= wr_en_nxt;
            wr_addr     <= wr_addr_nxt;
            upd_start   <= upd_start_nxt;
            vga_own     <= vga_own_nxt;
            busy        <= busy_nxt;
            gen_count   <= gen_count_nxt;
            err         <= err_nxt;
            frame_cnt   <= frame_cnt_nxt;
            step_pend   <= step_pend_nxt;
            reseed_pend <= reseed_pend_nxt;
            tcnt        <= tcnt_nxt;
        end
    end

    // Next-state logic: seed sweep, frame-boundary scheduling, update watchdog
    always_comb begin
        state_nxt       = state;
        wr_en_nxt       = wr_en;
        wr_addr_nxt     = wr_addr;
        upd_start_nxt   = 1'b0;
        vga_own_nxt     = vga_own;
        busy_nxt        = busy;
        gen_count_nxt   = gen_count;
        err_nxt         = err;
        frame_cnt_nxt   = frame_cnt;
        step_pend_nxt   = step_pend;
        reseed_pend_nxt = reseed_pend;
        tcnt_nxt        = tcnt;

        unique case (state)
            SEED: begin
                if (!wr_en) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = '0;
                end else if (wr_addr != AW'(N - 1)) begin
                    wr_addr_nxt = wr_addr + AW'(1);
                end else begin
                    wr_en_nxt   = 1'b0;
                    wr_addr_nxt = '0;
                    state_nxt   = IDLE;
                    vga_own_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end
            end
            IDLE: begin
                if (frame_start) begin
                    if (reseed_pend) begin
                        state_nxt       = SEED;
                        gen_count_nxt   = '0;
                        frame_cnt_nxt   = '0;
                        reseed_pend_nxt = 1'b0;
                        step_pend_nxt   = 1'b0;
                        vga_own_nxt     = 1'b0;
                        busy_nxt        = 1'b1;
                    end else if (step_pend ||
                                 (run && frame_cnt == FW'(GEN_DIV - 1))) begin
                        state_nxt     = UPDATE;
                        upd_start_nxt = 1'b1;
                        vga_own_nxt   = 1'b0;
                        busy_nxt      = 1'b1;
                        frame_cnt_nxt = '0;
                        step_pend_nxt = 1'b0;
                        tcnt_nxt      = '0;
                    end else if (run) begin
                        frame_cnt_nxt = frame_cnt + FW'(1);
                    end
                end
            end
            UPDATE: begin
                tcnt_nxt = tcnt + TW'(1);
                // The engine cannot be done in the cycle it is being started
                if (upd_done && !upd_start) begin
                    state_nxt     = IDLE;
                    gen_count_nxt = gen_count + 16'd1;
                    vga_own_nxt   = 1'b1;
                    busy_nxt      = 1'b0;
                end else if (tcnt == TW'(UPD_TIMEOUT - 1)) begin
                    err_nxt     = 1'b1;
                    state_nxt   = IDLE;
                    vga_own_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = SEED;
            end
        endcase

        // Requests are latched after the state actions so a new one is never lost
        if (step && !run && state != SEED) begin
            step_pend_nxt = 1'b1;
        end
        if (reseed) begin
            reseed_pend_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_lifegame_frame_sequencer.sv
// Directed bench for lifegame_frame_sequencer.
// Small 8x4 board, two frames per generation, 100-cycle update watchdog.
module tb_lifegame_frame_sequencer;

    localparam int COLS = 8;
    localparam int ROWS = 4;
    localparam int N    = COLS * ROWS;
    localparam int AW   = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          seed_bit;
    logic          frame_start;
    logic          run;
    logic          step;
    logic          reseed;
    logic          upd_done;
    logic          upd_start;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          vga_own;
    logic          busy;
    logic [15:0]   gen_count;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;
    int n_starts = 0;
    int exp_gen = 0;
    int s0;

    lifegame_frame_sequencer #(
        .COLS(COLS),
        .ROWS(ROWS),
        .GEN_DIV(2),
        .UPD_TIMEOUT(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seed_bit(seed_bit),
        .frame_start(frame_start),
        .run(run),
        .step(step),
        .reseed(reseed),
        .upd_done(upd_done),
        .upd_start(upd_start),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .vga_own(vga_own),
        .busy(busy),
        .gen_count(gen_count),
        .err(err)
    );

    always #5 clk = ~clk;

    // Counts cycles in which the update engine was being started
    always @(posedge clk) begin
        if (upd_start === 1'b1) n_starts <= n_starts + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    task automatic seed_sweep();
        for (int i = 0; i < N; i++) begin
            cyc();
            seed_bit = 1'($urandom_range(0, 1));
            #1;
            check("seed_wr_en", 32'(wr_en), 32'd1);
            check("seed_addr", 32'(wr_addr), 32'(i));
            check("seed_data", 32'(wr_data), 32'(seed_bit));
        end
        cyc();
        check("seed_end_wr_en", 32'(wr_en), 32'd0);
        check("seed_end_vga", 32'(vga_own), 32'd1);
        check("seed_end_busy", 32'(busy), 32'd0);
    endtask

    // Called right after the edge that raised upd_start
    task automatic finish_update();
        cyc();
        check("start_one_cycle", 32'(upd_start), 32'd0);
        check("upd_busy", 32'(busy), 32'd1);
        repeat (8) cyc();
        upd_done = 1'b1;
        cyc();
        upd_done = 1'b0;
        exp_gen++;
        check("done_vga", 32'(vga_own), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_gen", 32'(gen_count), 32'(exp_gen));
    endtask

    initial begin
        rst = 1'b0;
        seed_bit = 1'b1;
        frame_start = 1'b0;
        run = 1'b0;
        step = 1'b0;
        reseed = 1'b0;
        upd_done = 1'b0;
        repeat (3) cyc();

        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_upd_start", 32'(upd_start), 32'd0);
        check("rst_vga", 32'(vga_own), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_gen", 32'(gen_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        rst = 1'b1;
        seed_sweep();

        // Free-run: a generation every second frame
        run = 1'b1;
        s0 = n_starts;
        for (int p = 1; p <= 4; p++) begin
            pulse_frame();
            check("run_start", 32'(upd_start), 32'(p % 2 == 0));
            check("run_vga", 32'(vga_own), 32'(p % 2 != 0));
            if (p % 2 == 0) finish_update();
            else repeat (3) cyc();
        end
        check("run_starts", 32'(n_starts - s0), 32'd2);
        check("run_gen", 32'(gen_count), 32'd2);

        // Single-step: one generation at the first frame after the step
        run = 1'b0;
        cyc();
        pulse_step();
        s0 = n_starts;
        pulse_frame();
        check("step_start", 32'(upd_start), 32'd1);
        upd_done = 1'b1;
        cyc();
        upd_done = 1'b0;
        check("early_done_vga", 32'(vga_own), 32'd0);
        check("early_done_busy", 32'(busy), 32'd1);
        finish_update();
        pulse_frame();
        check("step_second_frame", 32'(upd_start), 32'd0);
        check("step_second_vga", 32'(vga_own), 32'd1);
        cyc();
        check("step_starts", 32'(n_starts - s0), 32'd1);

        // Step while running is dropped
        run = 1'b1;
        pulse_step();
        run = 1'b0;
        cyc();
        pulse_frame();
        check("step_dropped", 32'(upd_start), 32'd0);

        // Reseed requested during an update waits for completion
        pulse_step();
        pulse_frame();
        check("rs_start", 32'(upd_start), 32'd1);
        cyc();
        reseed = 1'b1;
        cyc();
        reseed = 1'b0;
        repeat (3) cyc();
        check("rs_still_upd", 32'(vga_own), 32'd0);
        upd_done = 1'b1;
        cyc();
        upd_done = 1'b0;
        exp_gen++;
        check("rs_done_gen", 32'(gen_count), 32'(exp_gen));
        check("rs_done_vga", 32'(vga_own), 32'd1);
        repeat (2) cyc();
        pulse_frame();
        exp_gen = 0;
        check("rs_seed_vga", 32'(vga_own), 32'd0);
        check("rs_seed_busy", 32'(busy), 32'd1);
        check("rs_seed_gen", 32'(gen_count), 32'd0);
        check("rs_no_start", 32'(upd_start), 32'd0);
        seed_sweep();

        // Watchdog: no upd_done for 100 cycles
        pulse_step();
        pulse_frame();
        check("to_start", 32'(upd_start), 32'd1);
        repeat (99) cyc();
        check("to_pre_err", 32'(err), 32'd0);
        check("to_pre_busy", 32'(busy), 32'd1);
        cyc();
        check("to_err", 32'(err), 32'd1);
        check("to_vga", 32'(vga_own), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_gen", 32'(gen_count), 32'd0);
        upd_done = 1'b1;
        cyc();
        upd_done = 1'b0;
        check("idle_done_ignored", 32'(gen_count), 32'd0);
        pulse_step();
        pulse_frame();
        check("post_to_start", 32'(upd_start), 32'd1);
        finish_update();
        check("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of an update
        pulse_step();
        pulse_frame();
        check("mr_start", 32'(upd_start), 32'd1);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("mr_upd_start", 32'(upd_start), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        check("mr_gen", 32'(gen_count), 32'd0);
        check("mr_busy", 32'(busy), 32'd1);
        check("mr_vga", 32'(vga_own), 32'd0);
        check("mr_wr_en", 32'(wr_en), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        check("mr_seed_en", 32'(wr_en), 32'd1);
        check("mr_seed_addr0", 32'(wr_addr), 32'd0);
        cyc();
        check("mr_seed_addr1", 32'(wr_addr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
